hdmi_timing_gen: RTL and testbench

- Video timing generator directly downstream of the HDMI I2C configuration block.
- Holds the HDMI transmitter's video inputs idle until configuration reports DONE, waits a settle interval, then produces hsync/vsync/de plus pixel coordinates for the pixel source feeding the transmitter.
- Runs on the system clock; pixel rate is set by a clock-enable.

---
 rtl/hdmi_timing_gen.sv | 124 ++++++++++++
 tb/tb_hdmi_timing_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Video timing generator for the HDMI transmitter.
// Holds the video outputs idle until the I2C configuration block reports done.
// After a settle interval it produces hsync, vsync, de, pixel coordinates and
// line/frame start pulses. Pixel rate is set by pix_ce.
module hdmi_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_MSB       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_done,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_MSB:0] pix_x,
  output logic [CNT_MSB:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int CW      = CNT_MSB + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_CFG, SETTLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_cnt;
  logic [CW-1:0]   h_cnt, v_cnt;
  logic            h_act, v_act, hs_on, vs_on;

  // Decode of the current counter position; registered below.
  assign h_act = (h_cnt < H_ACT);
  assign v_act = (v_cnt < V_ACT);
  assign hs_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= WAIT_CFG;
    else      state_q <= state_d;
  end

  // Next state: losing cfg_done always falls back to WAIT_CFG.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CFG: if (cfg_done) state_d = SETTLE;
      SETTLE: begin
        if (!cfg_done)                state_d = WAIT_CFG;
        else if (settle_cnt == S_LAST) state_d = RUN;
      end
      RUN:      if (!cfg_done) state_d = WAIT_CFG;
      default:  state_d = WAIT_CFG;
    endcase
  end

  // Settle counter: counts system clocks, restarts at 0 on entry to SETTLE.
  always_ff @(posedge clk) begin
    if (!rst)                  settle_cnt <= '0;
    else if (state_q == SETTLE) settle_cnt <= settle_cnt + SW'(1);
    else                       settle_cnt <= '0;
  end

  // Raster counters and registered outputs; idle whenever not heading into RUN.
  always_ff @(posedge clk) begin
    if (!rst || state_d != RUN) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      running     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      // The RUN entry edge only starts the clock; (0,0) is output on the next pix_ce.
      if (state_q == RUN && pix_ce) begin
        de          <= h_act && v_act;
        hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        pix_x       <= h_act ? h_cnt : '0;
        pix_y       <= v_act ? v_cnt : '0;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Scoreboard bench for hdmi_timing_gen using a reduced raster:
// 16 clocks per line (8 active, hsync h=10..12) and 9 lines per frame
// (4 active, vsync v=5..6). Settle interval is 8 clocks.
// Expected output snapshots are tagged with the clock edge they belong to.
module tb_hdmi_timing_gen;

  logic        clk = 1'b0;
  logic        rst, cfg_done, pix_ce;
  logic        hsync, vsync, de, line_start, frame_start, running;
  logic [11:0] pix_x, pix_y;

  hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .SETTLE_CYCLES(8), .CNT_MSB(11)
  ) dut (
    .clk(clk), .rst(rst), .cfg_done(cfg_done), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic run, fs, ls, de, hs, vs;
    logic [11:0] x, y;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Edge counter: at the negedge after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk(input logic run, fs, ls, d, hs, vs,
                               input int x, input int y);
    snap_t s;
    s.run = run; s.fs = fs; s.ls = ls; s.de = d; s.hs = hs; s.vs = vs;
    s.x = 12'(x); s.y = 12'(y);
    return s;
  endfunction

  task automatic push(input int c, input snap_t s, input string nm);
    exp_t e;
    e.cyc = c; e.s = s; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Monitor: compare every expectation that falls due on this edge.
  always @(negedge clk) begin
    snap_t got;
    exp_t  e;
    got = {running, frame_start, line_start, de, hsync, vsync, pix_x, pix_y};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_chk++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: cycle %0d passed unchecked (now %0d)", e.nm, e.cyc, cyc);
      end else if (got !== e.s) begin
        n_fail++;
        $display("FAIL %s @%0d: got run=%b fs=%b ls=%b de=%b hs=%b vs=%b x=%0d y=%0d, want run=%b fs=%b ls=%b de=%b hs=%b vs=%b x=%0d y=%0d",
                 e.nm, cyc, got.run, got.fs, got.ls, got.de, got.hs, got.vs, got.x, got.y,
                 e.s.run, e.s.fs, e.s.ls, e.s.de, e.s.hs, e.s.vs, e.s.x, e.s.y);
      end
    end
  end

  initial begin
    snap_t idle, run_idle;
    idle     = mk(0,0,0,0,1,1,0,0);
    run_idle = mk(1,0,0,0,1,1,0,0);

    // Reset held 4 clocks with cfg_done and pix_ce high, then 2 idle clocks.
    for (int c = 1; c <= 6; c++) push(c, idle, "reset_idle");
    rst = 1'b0; cfg_done = 1'b1; pix_ce = 1'b1;
    wait_cyc(4);
    rst = 1'b1; cfg_done = 1'b0;

    // Start-up with pix_ce tied high: cfg_done seen at edge 7, RUN at 15,
    // position p of the frame appears at edge 16+p.
    wait_cyc(6);
    push(7,   idle,                       "settle_start");
    push(14,  idle,                       "settle_end_no_de");
    push(15,  run_idle,                   "run_entry");
    push(16,  mk(1,1,1,1,1,1,0,0),        "first_pixel_0_0");
    push(17,  mk(1,0,0,1,1,1,1,0),        "pixel_1_0");
    push(23,  mk(1,0,0,1,1,1,7,0),        "last_active_h");
    push(24,  mk(1,0,0,0,1,1,0,0),        "front_porch_h");
    push(26,  mk(1,0,0,0,0,1,0,0),        "hsync_first");
    push(28,  mk(1,0,0,0,0,1,0,0),        "hsync_last");
    push(29,  mk(1,0,0,0,1,1,0,0),        "hsync_end");
    push(32,  mk(1,0,1,1,1,1,0,1),        "line1_start");
    push(69,  mk(1,0,0,1,1,1,5,3),        "pixel_5_3");
    push(80,  mk(1,0,1,0,1,1,0,0),        "blank_line4");
    push(96,  mk(1,0,1,0,1,0,0,0),        "vsync_first_line");
    push(106, mk(1,0,0,0,0,0,0,0),        "hsync_in_vsync");
    push(127, mk(1,0,0,0,1,0,0,0),        "vsync_last_pixel");
    push(128, mk(1,0,1,0,1,1,0,0),        "vsync_end");
    push(159, run_idle,                   "frame_last_pixel");
    push(160, mk(1,1,1,1,1,1,0,0),        "frame2_start");
    // Abort in frame 2 at line 2, h=5 (edge 197), cfg_done dropped after it.
    push(197, mk(1,0,0,1,1,1,5,2),        "pre_abort_pixel");
    push(198, idle,                       "abort_idle");
    push(199, idle,                       "abort_hold");
    cfg_done = 1'b1;

    wait_cyc(197);
    cfg_done = 1'b0;

    // Restart with pix_ce on every edge that is a multiple of 3.
    wait_cyc(199);
    push(207, idle,                       "resettle_end");
    push(208, run_idle,                   "rerun_entry");
    push(209, run_idle,                   "rerun_wait_ce");
    push(210, mk(1,1,1,1,1,1,0,0),        "restart_frame_0_0");
    push(211, mk(1,0,0,1,1,1,0,0),        "pulse_1clk");
    push(212, mk(1,0,0,1,1,1,0,0),        "x0_hold");
    push(213, mk(1,0,0,1,1,1,1,0),        "x1_step");
    push(215, mk(1,0,0,1,1,1,1,0),        "x1_hold");
    push(216, mk(1,0,0,1,1,1,2,0),        "x2_step");
    push(240, mk(1,0,0,0,0,1,0,0),        "ce3_hsync");
    push(241, mk(1,0,0,0,0,1,0,0),        "ce3_hsync_hold");
    push(258, mk(1,0,1,1,1,1,0,1),        "ce3_line1_start");
    push(259, mk(1,0,0,1,1,1,0,1),        "ce3_line1_pulse_end");
    push(306, mk(1,0,1,1,1,1,0,2),        "ce3_line2_start");
    cfg_done = 1'b1;
    while (cyc < 310) begin
      pix_ce = ((cyc + 1) % 3 == 0);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
